// File: rtl/maple_frame_decoder.sv
// Receive-side Maple bus frame decoder: start/data/end framing, byte output, error reporting.
// Optional checksum check of the running byte XOR is enabled by defining MAPLE_DEC_CHECKSUM_EN.
module maple_frame_decoder #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sdcka,
  input  logic       sdckb,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_start,
  output logic       rx_end,
  output logic       rx_err,
  output logic [1:0] rx_err_code,
  output logic       busy
);
  // state     | meaning
  // IDLE      | bus idle, waiting for A fall with B high
  // START     | counting B falls while A low
  // DATA      | even bit: A fall samples B, odd bit: B fall samples A
  // END       | counting A falls while B low
  // ERR       | one-cycle error report
  // WAIT_IDLE | waiting for both lines high
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_END       = 3'd3;
  localparam logic [2:0] S_ERR       = 3'd4;
  localparam logic [2:0] S_WAIT_IDLE = 3'd5;

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_RELOAD = TW'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] a_sync_q, a_sync_d, b_sync_q, b_sync_d, settle_q, settle_d;
  logic                   a_hist_q, a_hist_d, b_hist_q, b_hist_d;
  logic                   arm_q, arm_d;
  logic [2:0]             state_q, state_d;
  logic [2:0]             cnt_q, cnt_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic [6:0]             shift_q, shift_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic [7:0]             rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   rx_start_q, rx_start_d;
  logic                   rx_end_q, rx_end_d;
  logic [1:0]             code_q, code_d;
`ifdef MAPLE_DEC_CHECKSUM_EN
  logic [7:0]             csum_q, csum_d;
`endif

  logic a_s, b_s, a_fall, a_rise, b_fall, b_rise, both_fall, any_edge, active;

  always_comb begin
    a_sync_d = {a_sync_q[SYNC_STAGES-2:0], sdcka};
    b_sync_d = {b_sync_q[SYNC_STAGES-2:0], sdckb};
    settle_d = {settle_q[SYNC_STAGES-2:0], 1'b1};
    a_s      = a_sync_q[SYNC_STAGES-1];
    b_s      = b_sync_q[SYNC_STAGES-1];
    a_hist_d = a_s;
    b_hist_d = b_s;
    a_fall   = a_hist_q & ~a_s;
    a_rise   = ~a_hist_q & a_s;
    b_fall   = b_hist_q & ~b_s;
    b_rise   = ~b_hist_q & b_s;
    both_fall = a_fall & b_fall;
    any_edge = a_fall | a_rise | b_fall | b_rise;
    active   = (state_q == S_START) || (state_q == S_DATA) || (state_q == S_END);
    // Start detection is blocked until the chain holds real pin samples and both lines were high.
    arm_d    = arm_q | ((&settle_q) & a_s & b_s);
  end

  always_comb begin
    logic       take;
    logic       nbit;
    logic [7:0] byte_w;
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_start_d = 1'b0;
    rx_end_d   = 1'b0;
    code_d     = code_q;
    take       = 1'b0;
    nbit       = 1'b0;
`ifdef MAPLE_DEC_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    tmo_d = (any_edge || !active || tmo_q == '0) ? TMO_RELOAD : tmo_q - TW'(1);

    case (state_q)
      S_IDLE: if (arm_q && a_fall && b_s) begin
        state_d = S_START;
        cnt_d   = 3'd0;
      end
      S_START: begin
        if (both_fall) begin
          state_d = S_ERR; code_d = 2'd0;
        end else if (a_rise) begin
          if (cnt_q == 3'd4) begin
            state_d    = S_DATA;
            rx_start_d = 1'b1;
            bit_idx_d  = 3'd0;
`ifdef MAPLE_DEC_CHECKSUM_EN
            csum_d     = 8'h00;
`endif
          end else begin
            state_d = S_ERR; code_d = 2'd0;
          end
        end else if (b_fall && !a_s && cnt_q != 3'd7) begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_DATA: begin
        if (both_fall) begin
          state_d = S_ERR; code_d = 2'd0;
        end else if (!bit_idx_q[0]) begin
          if (a_fall) begin
            take = 1'b1; nbit = b_s;
          end else if (b_fall) begin
            // B falling with A high in an A-clock slot is the end pattern.
            if (!a_s) begin
              state_d = S_ERR; code_d = 2'd0;
            end else if (bit_idx_q != 3'd0) begin
              state_d = S_ERR; code_d = 2'd2;
            end else begin
              state_d = S_END; cnt_d = 3'd0;
            end
          end
        end else begin
          if (b_fall) begin
            take = 1'b1; nbit = a_s;
          end else if (a_fall) begin
            state_d = S_ERR; code_d = 2'd0;
          end
        end
      end
      S_END: begin
        if (both_fall) begin
          state_d = S_ERR; code_d = 2'd0;
        end else if (b_rise) begin
          if (cnt_q == 3'd2) begin
            rx_end_d = 1'b1;
            state_d  = S_IDLE;
`ifdef MAPLE_DEC_CHECKSUM_EN
            if (csum_q != 8'h00) begin
              state_d = S_ERR; code_d = 2'd3;
            end
`endif
          end else begin
            state_d = S_ERR; code_d = 2'd0;
          end
        end else if (a_fall && !b_s && cnt_q != 3'd7) begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_ERR:       state_d = S_WAIT_IDLE;
      S_WAIT_IDLE: if (a_s && b_s) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase

    byte_w = {shift_q, nbit};
    if (take) begin
      shift_d   = byte_w[6:0];
      bit_idx_d = bit_idx_q + 3'd1;
      if (bit_idx_q == 3'd7) begin
        rx_data_d  = byte_w;
        rx_valid_d = 1'b1;
`ifdef MAPLE_DEC_CHECKSUM_EN
        csum_d     = csum_q ^ byte_w;
`endif
      end
    end

    if (active && !any_edge && tmo_q == '0) begin
      state_d = S_ERR; code_d = 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sync_q   <= '1;
      b_sync_q   <= '1;
      settle_q   <= '0;
      a_hist_q   <= 1'b1;
      b_hist_q   <= 1'b1;
      arm_q      <= 1'b0;
      state_q    <= S_IDLE;
      cnt_q      <= 3'd0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 7'd0;
      tmo_q      <= TMO_RELOAD;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      rx_start_q <= 1'b0;
      rx_end_q   <= 1'b0;
      code_q     <= 2'd0;
`ifdef MAPLE_DEC_CHECKSUM_EN
      csum_q     <= 8'h00;
`endif
    end else begin
      a_sync_q   <= a_sync_d;
      b_sync_q   <= b_sync_d;
      settle_q   <= settle_d;
      a_hist_q   <= a_hist_d;
      b_hist_q   <= b_hist_d;
      arm_q      <= arm_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tmo_q      <= tmo_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_start_q <= rx_start_d;
      rx_end_q   <= rx_end_d;
      code_q     <= code_d;
`ifdef MAPLE_DEC_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign rx_start    = rx_start_q;
  assign rx_end      = rx_end_q;
  assign rx_err      = (state_q == S_ERR);
  assign rx_err_code = code_q;
  assign busy        = (state_q != S_IDLE);
endmodule
